// File: rtl/ps2_movement_decoder.sv
// PS/2 keyboard receiver and arrow-key movement decoder.
// Deframes 11-bit scan-code frames from raw PS/2 clock/data, tracks make/break
// state of the four arrow keys and presents them as held-key levels.
// Optional: define PS2_WASD_EN to let the W/A/S/D letter keys drive the same
// outputs in parallel with the arrows.
module ps2_movement_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       turn_right,
    output logic       turn_left,
    output logic       move_forward,
    output logic       move_backward,
    output logic [7:0] scan_code,
    output logic       frame_valid,
    output logic       frame_error
);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // Bit positions of the held-key vectors.
    localparam int unsigned KeyRight = 0;
    localparam int unsigned KeyLeft  = 1;
    localparam int unsigned KeyFwd   = 2;
    localparam int unsigned KeyBack  = 3;

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeBrk   = 8'hF0;
    localparam logic [7:0] CodeUp    = 8'h75;
    localparam logic [7:0] CodeDown  = 8'h72;
    localparam logic [7:0] CodeLeft  = 8'h6B;
    localparam logic [7:0] CodeRight = 8'h74;
`ifdef PS2_WASD_EN
    localparam logic [7:0] CodeW     = 8'h1D;
    localparam logic [7:0] CodeS     = 8'h1B;
    localparam logic [7:0] CodeA     = 8'h1C;
    localparam logic [7:0] CodeD     = 8'h23;
`endif

    // Synchroniser and edge detector
    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;
    logic       ps2_fall;
    logic       ps2_bit;

    // Receiver state
    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]       scan_q, scan_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;

    // Decoder state
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [3:0] arrow_q, arrow_d;
    logic [3:0] letter_q, letter_d;

    // Two-stage synchronisers plus a delayed clock copy for falling-edge detection.
    // They reset to 1 (idle line level) so reset itself never fakes an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign ps2_fall = clk_prev_q & ~clk_sync_q[1];
    assign ps2_bit  = dat_sync_q[1];

    // Receiver state register and registered pulse outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tmo_cnt_q <= '0;
            scan_q    <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_cnt_q <= tmo_cnt_d;
            scan_q    <= scan_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    // Receiver next-state: frame deframing, parity/stop check and inactivity timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_cnt_d = '0;
        scan_d    = scan_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A high "start" bit is line noise, not a frame.
                if (ps2_fall && !ps2_bit) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (ps2_fall) begin
                    shift_d   = {ps2_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (ps2_fall) begin
                    parity_d = ps2_bit;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (ps2_fall) begin
                    state_d = StIdle;
                    // Odd parity: XOR over data and parity bit must be 1.
                    if (ps2_bit && (^{shift_q, parity_q})) begin
                        valid_d = 1'b1;
                        scan_d  = shift_q;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout only runs mid-frame and restarts on every PS/2 clock edge.
        if (state_q != StIdle && !ps2_fall) begin
            if (tmo_cnt_q == TimeoutLast) begin
                state_d = StIdle;
                error_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
        end
    end

    // Decoder state register: prefix flags and held-key bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            arrow_q  <= '0;
            letter_q <= '0;
        end else begin
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            arrow_q  <= arrow_d;
            letter_q <= letter_d;
        end
    end

    // Decoder next-state: acts on the frame_valid / frame_error cycle.
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        arrow_d  = arrow_q;
        letter_d = letter_q;

        if (error_q) begin
            // A dropped frame may have been a prefix; forget it.
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (valid_q) begin
            if (scan_q == CodeExt) begin
                ext_d = 1'b1;
            end else if (scan_q == CodeBrk) begin
                brk_d = 1'b1;
            end else begin
                if (ext_q) begin
                    case (scan_q)
                        CodeUp:    arrow_d[KeyFwd]   = ~brk_q;
                        CodeDown:  arrow_d[KeyBack]  = ~brk_q;
                        CodeLeft:  arrow_d[KeyLeft]  = ~brk_q;
                        CodeRight: arrow_d[KeyRight] = ~brk_q;
                        default:   ;
                    endcase
                end
`ifdef PS2_WASD_EN
                else begin
                    case (scan_q)
                        CodeW:   letter_d[KeyFwd]   = ~brk_q;
                        CodeS:   letter_d[KeyBack]  = ~brk_q;
                        CodeA:   letter_d[KeyLeft]  = ~brk_q;
                        CodeD:   letter_d[KeyRight] = ~brk_q;
                        default: ;
                    endcase
                end
`endif
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // Arrow and letter holds are tracked separately so releasing one keeps the other.
    assign turn_right    = arrow_q[KeyRight] | letter_q[KeyRight];
    assign turn_left     = arrow_q[KeyLeft]  | letter_q[KeyLeft];
    assign move_forward  = arrow_q[KeyFwd]   | letter_q[KeyFwd];
    assign move_backward = arrow_q[KeyBack]  | letter_q[KeyBack];
    assign scan_code     = scan_q;
    assign frame_valid   = valid_q;
    assign frame_error   = error_q;

endmodule
